// File: rtl/nes_pkg.sv
// Shared NES definitions: bus widths, the two register addresses the OAM
// DMA engine cares about, and the DMA engine state encoding.
package nes_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // CPU write here with a page number starts a sprite DMA.
    localparam logic [ADDR_W-1:0] DMA_REG_ADDR = 16'h4014;
    // PPU OAM data port that every DMA write targets.
    localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM sprite DMA engine and CPU/DMA bus arbiter.
// A CPU write of a page number to DMA_REG_ADDR stalls the CPU and copies
// 256 bytes {page,00}..{page,FF} to OAMDATA_ADDR as READ/WRITE pairs, with
// every READ aligned to a parity-0 cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cpu_addr/d_out/we     CPU bus request (passed through while idle)
//   d_in                  shared bus read data
//   addr, d_out, we       arbitrated bus (combinational from state/CPU)
//   cpu_rdy               1 = CPU may advance
//   dma_active            1 whenever the engine owns the bus
module oam_dma
    import nes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d_out,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] d_out,
    output logic              we,
    output logic              cpu_rdy,
    output logic              dma_active
);

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] page;
    logic [DATA_W-1:0] latch;
    logic              parity;
    logic              trigger_c;

    // Only an idle engine accepts a new DMA request.
    assign trigger_c = (state == ST_IDLE) && cpu_we && (cpu_addr == DMA_REG_ADDR);

    // State, transfer counter, page, data latch and cycle parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            page   <= '0;
            latch  <= '0;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger_c) begin
                page <= cpu_d_out;
                cnt  <= '0;
            end
            if (state == ST_READ) begin
                latch <= d_in;
            end
            if (state == ST_WRITE) begin
                cnt <= DATA_W'(cnt + DATA_W'(1));
            end
        end
    end

    // Next state and bus arbitration.
    always_comb begin
        state_nxt  = state;
        addr       = '0;
        d_out      = '0;
        we         = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        unique case (state)
            ST_IDLE: begin
                addr       = cpu_addr;
                d_out      = cpu_d_out;
                we         = cpu_we;
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                if (trigger_c) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                // Next cycle has parity ~parity; READ must land on parity 0.
                state_nxt = parity ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                state_nxt = ST_READ;
            end
            ST_READ: begin
                addr      = {page, cnt};
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                addr      = OAMDATA_ADDR;
                d_out     = latch;
                we        = 1'b1;
                state_nxt = (cnt == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a byte-wide memory model answers bus reads,
// expected DMA reads/writes are queued at trigger time and popped as the
// engine produces them.
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic [7:0]  d_in;
    logic [15:0] addr;
    logic [7:0]  d_out;
    logic        we;
    logic        cpu_rdy;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q [$];
    logic [7:0]  wr_q [$];

    int total;
    int bad;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_d_out  (cpu_d_out),
        .cpu_we     (cpu_we),
        .d_in       (d_in),
        .addr       (addr),
        .d_out      (d_out),
        .we         (we),
        .cpu_rdy    (cpu_rdy),
        .dma_active (dma_active)
    );

    assign d_in = mem[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset, release, then idle for `idle_after` cycles so the current
    // cycle's parity is idle_after[0].
    task automatic do_reset(input int idle_after);
        rst       = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_d_out = 8'hAA;
        tick;
        tick;
        chk("rst_rdy", 16'(cpu_rdy), 16'h1);
        chk("rst_active", 16'(dma_active), 16'h0);
        chk("rst_addr_pass", addr, 16'h1234);
        rst = 1'b0;
        for (int i = 0; i < idle_after; i++) tick;
    endtask

    // Trigger a DMA from the current idle cycle and follow it to the end.
    task automatic do_transfer(input logic [7:0] page, input int stall_exp,
                               input int idle_exp, input int inject_at,
                               input int abort_read);
        int          stall;
        int          reads;
        int          idles;
        bit          aborted;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic [15:0] last_rd;

        cpu_addr  = 16'h4014;
        cpu_d_out = page;
        cpu_we    = 1'b1;
        #1;
        chk("trig_pass_addr", addr, 16'h4014);
        chk("trig_pass_we", 16'(we), 16'h1);
        chk("trig_pass_data", 16'(d_out), 16'(page));
        chk("trig_rdy", 16'(cpu_rdy), 16'h1);
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < 256; i++) begin
            rd_q.push_back({page, 8'(i)});
            wr_q.push_back(mem[{page, 8'(i)}]);
        end
        tick;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_d_out = 8'hAA;
        stall   = 0;
        reads   = 0;
        idles   = 0;
        aborted = 1'b0;
        last_rd = 16'h0;

        while (cpu_rdy === 1'b0 && stall < 700) begin
            stall++;
            if (we === 1'b1) begin
                chk("wr_addr", addr, 16'h2004);
                exp_d = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hXX;
                chk("wr_data", 16'(d_out), 16'(exp_d));
            end else if (addr !== 16'h0000) begin
                reads++;
                exp_a = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hXXXX;
                chk("rd_addr", addr, exp_a);
                last_rd = addr;
                if (reads == abort_read) rst = 1'b1;
            end else begin
                idles++;
                chk("halt_before_read", 16'(reads), 16'h0);
            end
            if (stall == inject_at) begin
                cpu_addr  = 16'h4014;
                cpu_d_out = 8'h05;
                cpu_we    = 1'b1;
            end else if (stall == inject_at + 1) begin
                cpu_addr  = 16'h1234;
                cpu_d_out = 8'hAA;
                cpu_we    = 1'b0;
            end
            tick;
            if (rst === 1'b1) begin
                rst     = 1'b0;
                aborted = 1'b1;
            end
        end

        if (aborted) begin
            chk("abort_rdy", 16'(cpu_rdy), 16'h1);
            chk("abort_active", 16'(dma_active), 16'h0);
            chk("abort_addr_pass", addr, 16'h1234);
            chk("abort_reads", 16'(reads), 16'(abort_read));
            rd_q.delete();
            wr_q.delete();
        end else begin
            chk("stall_cycles", 16'(stall), 16'(stall_exp));
            chk("halt_align_cycles", 16'(idles), 16'(idle_exp));
            chk("rd_q_empty", 16'(rd_q.size()), 16'h0);
            chk("wr_q_empty", 16'(wr_q.size()), 16'h0);
            chk("last_read", last_rd, {page, 8'hFF});
            chk("end_rdy", 16'(cpu_rdy), 16'h1);
            chk("end_active", 16'(dma_active), 16'h0);
            chk("end_addr_pass", addr, 16'h1234);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        cpu_addr  = 16'h0;
        cpu_d_out = 8'h0;
        cpu_we    = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a ^ (a >> 8) ^ 8'h5A);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i);

        // Trigger on a parity-0 cycle: HALT then READ, 513 stall cycles.
        do_reset(0);
        do_transfer(8'h02, 513, 1, -10, -1);

        // Trigger on a parity-1 cycle: HALT, ALIGN, READ, 514 stall cycles.
        do_reset(1);
        do_transfer(8'h02, 514, 2, -10, -1);

        // Page 3 holds 0x00..0xFF in order.
        do_reset(0);
        do_transfer(8'h03, 513, 1, -10, -1);

        // Reset at the 100th READ aborts; a retrigger restarts from cnt=0.
        do_reset(0);
        do_transfer(8'h02, 513, 1, -10, 100);
        do_transfer(8'h02, 513, 1, -10, -1);

        // A write of page 5 to the DMA register mid-transfer is ignored.
        do_reset(0);
        do_transfer(8'h02, 513, 1, 50, -1);

        // Highest page ends at 16'hFFFF and returns to idle.
        do_reset(1);
        do_transfer(8'hFF, 514, 2, -10, -1);

        // Reset coinciding with a trigger: no DMA starts.
        do_reset(0);
        rst       = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h02;
        cpu_we    = 1'b1;
        tick;
        rst       = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_we    = 1'b0;
        #1;
        chk("rst_trig_rdy", 16'(cpu_rdy), 16'h1);
        chk("rst_trig_active", 16'(dma_active), 16'h0);
        tick;
        chk("rst_trig_still_idle", 16'(dma_active), 16'h0);
        chk("rst_trig_pass", addr, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
